display_capture: RTL and testbench
==================================

# display_capture

Receive-side monitor for the multiplexed four-digit 7-segment bus driven by the top-level display logic (segment lines SA–SP plus active-low digit enables Disp1–Disp4). It samples the bus and applies a per-digit stability filter, then decodes each segment pattern back to a 4-bit hex value with a valid flag. It raises a frame pulse once all four digits have been captured. Used for on-board readback of what the display shows and as a checker in display-path benches.

## Interface
- STABLE_CYC, 4: consecutive identical sampled cycles required before a digit is captured (≥1)
- TIMEOUT_CYC, 1000000: consecutive cycles with no single enabled digit before Idle asserts (≥1)
---
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- SA, SB, SC, SD, SE, SF, SG  in  1 each  segment lines, active-low (0 = lit)
- SP  in  1  decimal point, active-low
- Disp1, Disp2, Disp3, Disp4  in  1 each  digit enables, active-low
- Dig1, Dig2, Dig3, Dig4  out  4 each  last decoded value per digit
- Dp  out  4  last captured decimal point per digit, bit0 = Disp1, active-high
- Vld  out  4  1 = last capture of that digit decoded to a hex value, bit0 = Disp1
- Frame  out  1  one-cycle pulse when all four digits have been captured since the previous Frame or Idle
- Erro  out  1  sticky; set on an illegal bus condition, cleared only by reset
- Idle  out  1  high while the bus has been without a single enabled digit for ≥ TIMEOUT_CYC cycles

## Operation
- Input stage: all 12 inputs are registered once per clk. The filter, decoder and counters use only the registered copy.
- Active digit: exactly one Disp low. Zero lows means no active digit. Two or more lows sets Erro and counts as no active digit.
- Stability counter: increments while the digit index and the 8-bit segment pattern equal the previous sampled cycle. It restarts at 1 on any change. It is held at 0 while no digit is active. It saturates at STABLE_CYC.
- Capture: occurs once, on the cycle the counter reaches STABLE_CYC. No re-capture happens until the pattern or digit changes.
- Capture writes, for the active digit only:
  - Dig: the decoded value.
  - Dp: the inverted SP.
  - Vld.
  - The digit's seen bit.
- Decode table (lit pattern gfedcba → value):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
- Blank pattern (00): Dig=0, Vld=0, no error.
- Any other pattern: Dig=0, Vld=0, Erro set.
- Frame: when a capture makes the seen mask 1111, Frame pulses in the same cycle as that capture and the seen mask clears. Repeat captures of an already-seen digit only update that digit's outputs.
- Idle counter:
  - Counts cycles with no active digit and saturates at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC, Idle asserts and the seen mask clears.
  - Any active-digit cycle zeroes the counter and deasserts Idle.
  - Dig, Dp and Vld hold their values while Idle is high.

## Timing
- Reset (reset=0 at an edge): all outputs 0. Input register, stability counter, idle counter and seen mask are 0. Reset applied mid-capture abandons the pending capture.
- Capture latency: bus held constant from before edge 1 → Dig/Dp/Vld update at edge STABLE_CYC+1. This is 1 cycle of input register plus STABLE_CYC stability cycles.
- Frame is registered alongside the capture and is high for exactly one cycle.
- Erro sets at the edge after the offending value is sampled, i.e. 2 edges after it appears on the pins.
- Idle: with no active digit from before edge 1, Idle rises at edge TIMEOUT_CYC+1. It falls at edge k+1 when an active digit is present before edge k.
- A pattern held for STABLE_CYC−1 cycles and then changed produces no capture.
- Glitch filtering is exact: any single differing sample restarts the count.

## Test plan
- STABLE_CYC=4: reset, then Disp1=0 with pattern 4F (pins SA..SG = 0,0,0,0,1,1,0) held 6 cycles → Dig1=3, Vld[0]=1 from edge 5; Frame stays 0.
- Scan digits 1–4 with values 1, 2, 3, 4, each held 5 cycles → Frame pulses once, in the cycle Dig4=4 appears. Seen mask then clears; a second full scan gives a second pulse.
- Pattern 5B on Disp2 held 3 cycles, then 6D held 5 cycles → Dig2 never shows 2; Dig2=5 after the 6D stability window.
- Disp1 and Disp3 both low → Erro=1 two edges later and stays 1 through later legal traffic. Undecodable pattern 0x01 on Disp4 → Erro=1, Dig4=0, Vld[3]=0.
- TIMEOUT_CYC=8: all Disp high for 10 cycles after capturing digits 1 and 2 → Idle=1 at edge 9, Dig1/Dig2 held. Then capturing digits 3 and 4 produces no Frame, because the seen mask was cleared.
- Drive reset=0 for one edge in the middle of a stability window → all outputs 0 on the next edge, no capture from the interrupted window.

Source files
------------

// File: rtl/display_capture_if.sv
// display_capture_if
// Bundles the multiplexed four-digit 7-segment bus with the decoded readback
// produced by display_capture.
//   Bus side (pins, active-low): SA..SG segments, SP decimal point,
//                                Disp1..Disp4 digit enables.
//   Readback side: Dig1..Dig4 decoded values, Dp/Vld per-digit flags
//                  (bit0 = Disp1), Frame pulse, Erro sticky error, Idle.
// The master modport is the bus driver / readback consumer, and the slave
// modport is the capture block.
interface display_capture_if;
  logic       SA, SB, SC, SD, SE, SF, SG, SP;
  logic       Disp1, Disp2, Disp3, Disp4;
  logic [3:0] Dig1, Dig2, Dig3, Dig4;
  logic [3:0] Dp;
  logic [3:0] Vld;
  logic       Frame;
  logic       Erro;
  logic       Idle;

  modport master (
    output SA, SB, SC, SD, SE, SF, SG, SP,
    output Disp1, Disp2, Disp3, Disp4,
    input  Dig1, Dig2, Dig3, Dig4, Dp, Vld, Frame, Erro, Idle
  );

  modport slave (
    input  SA, SB, SC, SD, SE, SF, SG, SP,
    input  Disp1, Disp2, Disp3, Disp4,
    output Dig1, Dig2, Dig3, Dig4, Dp, Vld, Frame, Erro, Idle
  );
endinterface

// File: rtl/display_capture.sv
// display_capture
// Receive-side monitor for a multiplexed four-digit 7-segment display bus.
// The pins are registered once, and a stability filter waits for STABLE_CYC
// identical samples of a single enabled digit. The captured pattern is then
// decoded back to a hex value. Frame pulses when all four digits have been
// captured. Idle flags a bus without an active digit for TIMEOUT_CYC cycles.
// Ports:
//   clk   - clock, all logic on the rising edge
//   reset - synchronous, active-low
//   bus   - display_capture_if.slave (pins in, decoded readback out)
module display_capture #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic              clk,
  input logic              reset,
  display_capture_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

  // The registered copy is kept active-high (1 = enabled / lit). Its reset
  // value of zero therefore reads as "no digit, blank" rather than as
  // "all four digits enabled".
  logic [3:0]    en_reg, en_prev_reg;
  logic [7:0]    lit_reg, lit_prev_reg;      // {dp, g, f, e, d, c, b, a}
  logic [SW-1:0] stab_reg, stab_next;
  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [3:0]    seen_reg, seen_next, seen_cap;
  logic [3:0]    dig_reg [4];
  logic [3:0]    dig_next [4];
  logic [3:0]    dp_reg, dp_next, vld_reg, vld_next;
  logic          frame_reg, frame_next;
  logic          erro_reg, erro_next;
  logic          idle_reg, idle_next;
  logic          one_hot, multi, same, capture, idle_hit;
  logic [3:0]    dec_val;
  logic          dec_ok, blank;

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_reg       <= '0;
      lit_reg      <= '0;
      en_prev_reg  <= '0;
      lit_prev_reg <= '0;
    end else begin
      en_reg       <= ~{bus.Disp4, bus.Disp3, bus.Disp2, bus.Disp1};
      lit_reg      <= ~{bus.SP, bus.SG, bus.SF, bus.SE, bus.SD, bus.SC, bus.SB, bus.SA};
      en_prev_reg  <= en_reg;
      lit_prev_reg <= lit_reg;
    end
  end

  // Stability filter. A capture fires only on the sample that brings the
  // run to STABLE_CYC. A run that is already saturated never re-fires,
  // which also covers STABLE_CYC = 1.
  always_comb begin
    one_hot   = (en_reg != 4'd0) && ((en_reg & (en_reg - 4'd1)) == 4'd0);
    multi     = (en_reg != 4'd0) && !one_hot;
    same      = (en_reg == en_prev_reg) && (lit_reg == lit_prev_reg);
    stab_next = '0;
    if (one_hot) begin
      if (same && stab_reg != '0)
        stab_next = (stab_reg == STABLE_MAX) ? stab_reg : stab_reg + SW'(1);
      else
        stab_next = SW'(1);
    end
    capture = one_hot && (stab_next == STABLE_MAX) && !(same && stab_reg == STABLE_MAX);
  end

  // Segment decoder on the lit gfedcba pattern.
  always_comb begin
    dec_val = 4'd0;
    dec_ok  = 1'b1;
    blank   = (lit_reg[6:0] == 7'h00);
    case (lit_reg[6:0])
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Per-digit capture write-enables. Only the single enabled digit updates.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign dig_next[gi] = (capture && en_reg[gi]) ? (dec_ok ? dec_val : 4'd0) : dig_reg[gi];
      assign dp_next[gi]  = (capture && en_reg[gi]) ? lit_reg[7] : dp_reg[gi];
      assign vld_next[gi] = (capture && en_reg[gi]) ? dec_ok : vld_reg[gi];
    end
  endgenerate

  // Idle timeout, seen mask, frame and error.
  always_comb begin
    idle_cnt_next = '0;
    if (!one_hot)
      idle_cnt_next = (idle_cnt_reg == TIMEOUT_MAX) ? idle_cnt_reg : idle_cnt_reg + TW'(1);
    idle_hit   = !one_hot && (idle_cnt_reg != TIMEOUT_MAX) && (idle_cnt_next == TIMEOUT_MAX);
    seen_cap   = seen_reg | (capture ? en_reg : 4'd0);
    seen_next  = seen_cap;
    frame_next = 1'b0;
    if (idle_hit) begin
      seen_next = 4'd0;
    end else if (seen_cap == 4'hF) begin
      seen_next  = 4'd0;
      frame_next = 1'b1;
    end
    idle_next = one_hot ? 1'b0 : (idle_hit ? 1'b1 : idle_reg);
    erro_next = erro_reg | multi | (capture && !dec_ok && !blank);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stab_reg     <= '0;
      idle_cnt_reg <= '0;
      seen_reg     <= '0;
      dp_reg       <= '0;
      vld_reg      <= '0;
      frame_reg    <= 1'b0;
      erro_reg     <= 1'b0;
      idle_reg     <= 1'b0;
      for (int i = 0; i < 4; i++) dig_reg[i] <= '0;
    end else begin
      stab_reg     <= stab_next;
      idle_cnt_reg <= idle_cnt_next;
      seen_reg     <= seen_next;
      dp_reg       <= dp_next;
      vld_reg      <= vld_next;
      frame_reg    <= frame_next;
      erro_reg     <= erro_next;
      idle_reg     <= idle_next;
      for (int i = 0; i < 4; i++) dig_reg[i] <= dig_next[i];
    end
  end

  assign bus.Dig1  = dig_reg[0];
  assign bus.Dig2  = dig_reg[1];
  assign bus.Dig3  = dig_reg[2];
  assign bus.Dig4  = dig_reg[3];
  assign bus.Dp    = dp_reg;
  assign bus.Vld   = vld_reg;
  assign bus.Frame = frame_reg;
  assign bus.Erro  = erro_reg;
  assign bus.Idle  = idle_reg;

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture
// Drives directed and random traffic on the display bus. A sample-history
// model predicts the readback, which is compared on every falling edge.
// Literal checks pin the scenarios from the test plan.
module tb_display_capture;
  localparam int S = 4;
  localparam int T = 8;

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] lit;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   frames = 0;

  display_capture_if bus();

  display_capture #(.STABLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: expected outputs plus the history of registered samples.
  logic [3:0] m_dig [4];
  logic [3:0] m_dp, m_vld, m_seen;
  logic       m_frame, m_erro, m_idle;
  samp_t      reg_copy;
  samp_t      hist [$];
  int         idle_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [7:0] lit);
    {bus.Disp4, bus.Disp3, bus.Disp2, bus.Disp1} = ~en;
    {bus.SP, bus.SG, bus.SF, bus.SE, bus.SD, bus.SC, bus.SB, bus.SA} = ~lit;
  endtask

  task automatic model_step();
    samp_t r;
    samp_t pins;
    int    n, idx, val;
    bit    act, cap, found;
    pins.en  = ~{bus.Disp4, bus.Disp3, bus.Disp2, bus.Disp1};
    pins.lit = ~{bus.SP, bus.SG, bus.SF, bus.SE, bus.SD, bus.SC, bus.SB, bus.SA};
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_dp = 0; m_vld = 0; m_seen = 0;
      m_frame = 0; m_erro = 0; m_idle = 0;
      reg_copy = '0;
      hist.delete();
      idle_run = 0;
      return;
    end
    r = reg_copy;
    reg_copy = pins;
    hist.push_back(r);
    if (hist.size() > S + 1) void'(hist.pop_front());
    m_frame = 0;
    act = ($countones(r.en) == 1);
    if ($countones(r.en) > 1) m_erro = 1;
    if (act) begin
      idle_run = 0;
      m_idle = 0;
    end else if (idle_run < T) begin
      idle_run++;
      if (idle_run == T) begin
        m_idle = 1;
        m_seen = 0;
      end
    end
    // A capture happens when the last S samples are one identical active
    // sample and the sample before them (if any) was something else.
    n = hist.size();
    cap = 0;
    if (act && n >= S) begin
      cap = 1;
      for (int k = n - S; k < n; k++) if (hist[k] !== r) cap = 0;
      if (n > S && hist[n-S-1] === r) cap = 0;
    end
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (r.en[i]) idx = i;
      found = 0;
      val = 0;
      for (int i = 0; i < 16; i++) if (tbl[i] == r.lit[6:0]) begin found = 1; val = i; end
      m_dig[idx] = 4'(val);
      m_vld[idx] = found;
      m_dp[idx]  = r.lit[7];
      if (!found && r.lit[6:0] != 7'h00) m_erro = 1;
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_frame = 1;
        m_seen = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("dig1", bus.Dig1, m_dig[0]);
    chk("dig2", bus.Dig2, m_dig[1]);
    chk("dig3", bus.Dig3, m_dig[2]);
    chk("dig4", bus.Dig4, m_dig[3]);
    chk("dp", bus.Dp, m_dp);
    chk("vld", bus.Vld, m_vld);
    chk("frame", bus.Frame, m_frame);
    chk("erro", bus.Erro, m_erro);
    chk("idle", bus.Idle, m_idle);
    if (bus.Frame === 1'b1) frames++;
  endtask

  // One clock: model advances on the rising edge, outputs compared on the fall.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    logic [3:0] en;
    logic [7:0] lit;
    int kind, len;
    drive(4'b0000, 8'h00);
    rst_n = 1'b0;
    hold(2);
    chk("rst_vld", bus.Vld, 4'h0);
    chk("rst_erro", bus.Erro, 1'b0);
    rst_n = 1'b1;

    // Digit 1 shows 3: capture appears at the fifth edge.
    drive(4'b0001, 8'h4F);
    hold(4);
    chk("d1_early", bus.Dig1, 4'h0);
    hold(1);
    chk("d1_val", bus.Dig1, 4'h3);
    chk("d1_vld", bus.Vld[0], 1'b1);
    hold(1);
    chk("d1_noframe", frames, 0);

    // Two full scans give two frames.
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 4; d++) begin
        lit = {1'b0, tbl[d+1]};
        drive(4'(1 << d), lit);
        hold(5);
      end
    chk("scan_frames", frames, 2);

    // A short 5B glitch is never captured; 6D is.
    drive(4'b0010, 8'h3F);
    hold(5);
    drive(4'b0010, 8'h5B);
    for (int i = 0; i < 3; i++) begin cyc(); chk("d2_not2", bus.Dig2 == 4'h2, 1'b0); end
    drive(4'b0010, 8'h6D);
    for (int i = 0; i < 5; i++) begin cyc(); chk("d2_not2", bus.Dig2 == 4'h2, 1'b0); end
    chk("d2_val", bus.Dig2, 4'h5);

    // Idle timeout clears the seen mask.
    drive(4'b0001, 8'h06); hold(5);
    drive(4'b0010, 8'h5B); hold(5);
    drive(4'b0000, 8'h00);
    hold(8);
    chk("idle_early", bus.Idle, 1'b0);
    hold(1);
    chk("idle_set", bus.Idle, 1'b1);
    hold(1);
    chk("idle_d1", bus.Dig1, 4'h1);
    chk("idle_d2", bus.Dig2, 4'h2);
    frames = 0;
    drive(4'b0100, 8'h4F); hold(5);
    drive(4'b1000, 8'h66); hold(5);
    chk("idle_noframe", frames, 0);
    chk("idle_clr", bus.Idle, 1'b0);

    // Two enables low, then an undecodable pattern.
    chk("erro_pre", bus.Erro, 1'b0);
    drive(4'b0101, 8'h06);
    cyc();
    chk("erro_e1", bus.Erro, 1'b0);
    cyc();
    chk("erro_e2", bus.Erro, 1'b1);
    drive(4'b1000, 8'h01);
    hold(5);
    chk("bad_d4", bus.Dig4, 4'h0);
    chk("bad_vld", bus.Vld[3], 1'b0);
    chk("erro_sticky", bus.Erro, 1'b1);

    // Reset in the middle of a stability window.
    drive(4'b0001, 8'h7F);
    hold(2);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_erro", bus.Erro, 1'b0);
    chk("mid_rst_d1", bus.Dig1, 4'h0);
    rst_n = 1'b1;
    hold(4);
    chk("mid_rst_nocap", bus.Dig1, 4'h0);
    hold(1);
    chk("mid_rst_cap", bus.Dig1, 4'h8);

    // Random traffic against the model.
    for (int seg = 0; seg < 350; seg++) begin
      kind = $urandom_range(0, 19);
      len = $urandom_range(1, 7);
      en = 4'(1 << $urandom_range(0, 3));
      lit = {1'($urandom_range(0, 1)), tbl[$urandom_range(0, 15)]};
      if (kind < 3) begin
        en = 4'b0000;
        len = $urandom_range(1, 12);
      end else if (kind == 3) begin
        en = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
      end else if (kind == 4) begin
        lit = 8'($urandom_range(0, 255));
      end else if (kind == 5) begin
        lit = {lit[7], 7'h00};
      end else if (kind == 6) begin
        rst_n = 1'b0;
        len = 1;
      end
      drive(en, lit);
      hold(len);
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
